// File: rtl/riscv_pkg.sv
// Shared load/store definitions: access-size encodings, LSU state encoding,
// fault codes and the captured-request record.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  // Fields of the accepted instruction still needed after the bus request is issued
  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] addr_lo;
    logic [4:0] rd;
    logic       we;
  } lsu_req_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  import riscv_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads,
// and legality checks for a funct3/address pair.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic            is_store,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned,
  output logic            illegal
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    be         = 4'b0000;
    wdata      = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        be    = 4'(4'b0001 << addr_lo);
        wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      F3_W: begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = (addr_lo != 2'b00);
      end
      F3_BU: illegal = is_store;
      F3_HU: begin
        illegal    = is_store;
        misaligned = addr_lo[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  // Select the addressed lane, then sign- or zero-extend to a full word
  always_comb begin
    lane_b    = 8'(rdata >> {addr_lo, 3'b000});
    lane_h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'h000000, lane_b};
      F3_HU:   load_data = {16'h0000, lane_h};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: accepts one EX memory op, runs it on the
// data-memory bus with a timeout, and presents the result for one DONE cycle.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic                ex_mem_re,
  input  logic                ex_mem_we,
  input  logic [2:0]          ex_funct3,
  input  logic [XLEN-1:0]     ex_addr,
  input  logic [XLEN-1:0]     ex_store_data,
  input  logic [4:0]          ex_addr_rd,
  output logic                stall,
  load_store_unit_if.master   dmem,
  output logic                wb_valid,
  output logic                wb_write,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                fault,
  output logic [1:0]          fault_code
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e       state;
  lsu_req_t         req_q;
  logic [CNT_W-1:0] busy_cnt;

  logic            mem_op;
  logic            op_is_store;
  logic [2:0]      al_funct3;
  logic [1:0]      al_addr_lo;
  logic            al_is_store;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_load_data;
  logic            al_misaligned;
  logic            al_illegal;

  assign mem_op      = ex_valid && (ex_mem_re || ex_mem_we);
  assign op_is_store = !ex_mem_re && ex_mem_we;
  assign stall       = !reset && ((state == ST_BUSY) || ((state == ST_IDLE) && mem_op));

  // Aligner looks at the presented instruction in IDLE, the captured one afterwards
  always_comb begin
    al_funct3   = req_q.funct3;
    al_addr_lo  = req_q.addr_lo;
    al_is_store = req_q.we;
    if (state == ST_IDLE) begin
      al_funct3   = ex_funct3;
      al_addr_lo  = ex_addr[1:0];
      al_is_store = op_is_store;
    end
  end

  lsu_align u_align (
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .is_store   (al_is_store),
    .store_data (ex_store_data),
    .rdata      (dmem.rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load_data),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      busy_cnt   <= '0;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.be    <= '0;
      dmem.wdata <= '0;
      wb_valid   <= 1'b0;
      wb_write   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end else begin
      fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_op) begin
            req_q    <= '{funct3: ex_funct3, addr_lo: ex_addr[1:0], rd: ex_addr_rd, we: op_is_store};
            busy_cnt <= '0;
            if (al_illegal || al_misaligned) begin
              state      <= ST_DONE;
              wb_valid   <= 1'b1;
              wb_write   <= 1'b0;
              wb_rd      <= ex_addr_rd;
              wb_data    <= '0;
              fault      <= 1'b1;
              fault_code <= al_illegal ? FAULT_ILLEGAL : FAULT_MISALIGN;
            end else begin
              state      <= ST_BUSY;
              dmem.req   <= 1'b1;
              dmem.we    <= op_is_store;
              dmem.addr  <= {ex_addr[XLEN-1:2], 2'b00};
              dmem.be    <= al_be;
              dmem.wdata <= al_wdata;
            end
          end
        end
        ST_BUSY: begin
          if (dmem.ack || (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            state      <= ST_DONE;
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.be    <= '0;
            dmem.wdata <= '0;
            wb_valid   <= 1'b1;
            wb_rd      <= req_q.rd;
            if (dmem.ack) begin
              wb_write <= !req_q.we && (req_q.rd != 5'd0);
              wb_data  <= req_q.we ? '0 : al_load_data;
            end else begin
              wb_write   <= 1'b0;
              wb_data    <= '0;
              fault      <= 1'b1;
              fault_code <= FAULT_TIMEOUT;
            end
          end else begin
            busy_cnt <= busy_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          wb_valid   <= 1'b0;
          wb_write   <= 1'b0;
          wb_rd      <= '0;
          wb_data    <= '0;
          fault_code <= FAULT_NONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected results are queued when an
// op is presented and compared when the unit reports write-back.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_re, ex_mem_we;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_store_data;
  logic [4:0]  ex_addr_rd;
  logic        stall, wb_valid, wb_write, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  fault_code;

  load_store_unit_if dmem ();

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_mem_re     (ex_mem_re),
    .ex_mem_we     (ex_mem_we),
    .ex_funct3     (ex_funct3),
    .ex_addr       (ex_addr),
    .ex_store_data (ex_store_data),
    .ex_addr_rd    (ex_addr_rd),
    .stall         (stall),
    .dmem          (dmem),
    .wb_valid      (wb_valid),
    .wb_write      (wb_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .fault         (fault),
    .fault_code    (fault_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic        write;
    logic [31:0] data;
    logic        chk_data;
    logic        fault;
    logic [1:0]  code;
    logic [31:0] addr;
    logic        we;
    logic        chk_lanes;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          n_req;
    int          n_stall;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] rd, input logic write, input logic [31:0] data,
                              input logic chk_data, input logic flt, input logic [1:0] code,
                              input logic [31:0] addr, input logic we, input logic chk_lanes,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input int n_req, input int n_stall);
    exp_t e;
    e.rd = rd; e.write = write; e.data = data; e.chk_data = chk_data;
    e.fault = flt; e.code = code; e.addr = addr; e.we = we; e.chk_lanes = chk_lanes;
    e.be = be; e.wdata = wdata; e.n_req = n_req; e.n_stall = n_stall;
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one op, answer the bus after 'waits' wait cycles (negative: never), check write-back
  task automatic do_op(input string tag, input logic re, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                       input logic [31:0] rdata, input int waits, input exp_t e);
    exp_t got;
    int   n_req   = 0;
    int   n_stall = 0;
    bit   done    = 1'b0;
    sb.push_back(e);
    ex_valid = 1'b1; ex_mem_re = re; ex_mem_we = we; ex_funct3 = f3;
    ex_addr = addr; ex_store_data = sd; ex_addr_rd = rd;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      dmem.ack   = dmem.req && (waits >= 0) && (n_req == waits);
      dmem.rdata = dmem.ack ? rdata : 32'h5A5A_5A5A;
      #1;
      if (stall) n_stall++;
      if (dmem.req) begin
        n_req++;
        check({tag, ".addr"}, dmem.addr, got.addr === 'x ? e.addr : e.addr);
        check({tag, ".we"}, 32'(dmem.we), 32'(e.we));
        if (e.chk_lanes) begin
          check({tag, ".be"}, 32'(dmem.be), 32'(e.be));
          check({tag, ".wdata"}, dmem.wdata, e.wdata);
        end
      end
      if (wb_valid) begin
        check({tag, ".sb_nonempty"}, 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          check({tag, ".wb_write"}, 32'(wb_write), 32'(got.write));
          check({tag, ".wb_rd"}, 32'(wb_rd), 32'(got.rd));
          check({tag, ".fault"}, 32'(fault), 32'(got.fault));
          check({tag, ".fault_code"}, 32'(fault_code), 32'(got.code));
          check({tag, ".stall_in_done"}, 32'(stall), 32'd0);
          if (got.chk_data) check({tag, ".wb_data"}, wb_data, got.data);
          check({tag, ".req_cycles"}, 32'(n_req), 32'(got.n_req));
          check({tag, ".stall_cycles"}, 32'(n_stall), 32'(got.n_stall));
        end
        done = 1'b1;
      end
      step();
    end
    check({tag, ".completed"}, 32'(done), 32'd1);
    ex_valid = 1'b0; ex_mem_re = 1'b0; ex_mem_we = 1'b0; dmem.ack = 1'b0;
    #1;
    check({tag, ".fault_pulse_end"}, 32'(fault), 32'd0);
    check({tag, ".wb_valid_end"}, 32'(wb_valid), 32'd0);
    check({tag, ".idle_stall"}, 32'(stall), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"}, 32'(stall), 32'd0);
    check({tag, ".dmem_req"}, 32'(dmem.req), 32'd0);
    check({tag, ".dmem_we"}, 32'(dmem.we), 32'd0);
    check({tag, ".dmem_addr"}, dmem.addr, 32'd0);
    check({tag, ".dmem_be"}, 32'(dmem.be), 32'd0);
    check({tag, ".dmem_wdata"}, dmem.wdata, 32'd0);
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'd0);
    check({tag, ".wb_write"}, 32'(wb_write), 32'd0);
    check({tag, ".wb_rd"}, 32'(wb_rd), 32'd0);
    check({tag, ".wb_data"}, wb_data, 32'd0);
    check({tag, ".fault"}, 32'(fault), 32'd0);
    check({tag, ".fault_code"}, 32'(fault_code), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired: observed no end of test, required end before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with an op presented: stall stays low, everything clears
    reset = 1'b1; ex_valid = 1'b1; ex_mem_re = 1'b1; ex_mem_we = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h100; ex_store_data = 32'h0; ex_addr_rd = 5'd5;
    dmem.ack = 1'b0; dmem.rdata = 32'h0;
    #1;
    check("reset.stall_forced", 32'(stall), 32'd0);
    step();
    step();
    check_all_zero("reset");
    ex_valid = 1'b0; ex_mem_re = 1'b0;
    reset = 1'b0;
    step();

    do_op("lw_100", 1, 0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0,
          mk(5'd5, 1, 32'hDEADBEEF, 1, 0, 2'b00, 32'h100, 0, 0, 4'h0, 32'h0, 1, 2));
    do_op("lb_103", 1, 0, 3'b000, 32'h103, 32'h0, 5'd6, 32'h80112233, 0,
          mk(5'd6, 1, 32'hFFFFFF80, 1, 0, 2'b00, 32'h100, 0, 0, 4'h0, 32'h0, 1, 2));
    do_op("lbu_103", 1, 0, 3'b100, 32'h103, 32'h0, 5'd6, 32'h80112233, 0,
          mk(5'd6, 1, 32'h00000080, 1, 0, 2'b00, 32'h100, 0, 0, 4'h0, 32'h0, 1, 2));
    do_op("sh_202", 0, 1, 3'b001, 32'h202, 32'h0000ABCD, 5'd9, 32'h0, 3,
          mk(5'd9, 0, 32'h0, 0, 0, 2'b00, 32'h200, 1, 1, 4'b1100, 32'hABCDABCD, 4, 5));
    do_op("lw_101", 1, 0, 3'b010, 32'h101, 32'h0, 5'd3, 32'h0, 0,
          mk(5'd3, 0, 32'h0, 0, 1, 2'b01, 32'h0, 0, 0, 4'h0, 32'h0, 0, 1));
    do_op("lh_101", 1, 0, 3'b001, 32'h101, 32'h0, 5'd3, 32'h0, 0,
          mk(5'd3, 0, 32'h0, 0, 1, 2'b01, 32'h0, 0, 0, 4'h0, 32'h0, 0, 1));
    do_op("sb_201", 0, 1, 3'b000, 32'h201, 32'h12345678, 5'd1, 32'h0, 1,
          mk(5'd1, 0, 32'h0, 0, 0, 2'b00, 32'h200, 1, 1, 4'b0010, 32'h78787878, 2, 3));
    do_op("sw_208", 0, 1, 3'b010, 32'h208, 32'hCAFEF00D, 5'd2, 32'h0, 0,
          mk(5'd2, 0, 32'h0, 0, 0, 2'b00, 32'h208, 1, 1, 4'b1111, 32'hCAFEF00D, 1, 2));
    do_op("lh_102", 1, 0, 3'b001, 32'h102, 32'h0, 5'd10, 32'h80017FFF, 2,
          mk(5'd10, 1, 32'hFFFF8001, 1, 0, 2'b00, 32'h100, 0, 0, 4'h0, 32'h0, 3, 4));
    do_op("lhu_102", 1, 0, 3'b101, 32'h102, 32'h0, 5'd10, 32'h80017FFF, 2,
          mk(5'd10, 1, 32'h00008001, 1, 0, 2'b00, 32'h100, 0, 0, 4'h0, 32'h0, 3, 4));
    do_op("sbu_illegal", 0, 1, 3'b100, 32'h200, 32'h0, 5'd4, 32'h0, 0,
          mk(5'd4, 0, 32'h0, 0, 1, 2'b11, 32'h0, 0, 0, 4'h0, 32'h0, 0, 1));
    do_op("ld_f3_011", 1, 0, 3'b011, 32'h200, 32'h0, 5'd4, 32'h0, 0,
          mk(5'd4, 0, 32'h0, 0, 1, 2'b11, 32'h0, 0, 0, 4'h0, 32'h0, 0, 1));
    do_op("re_we_prio", 1, 1, 3'b010, 32'h104, 32'h11111111, 5'd12, 32'h0BADF00D, 0,
          mk(5'd12, 1, 32'h0BADF00D, 1, 0, 2'b00, 32'h104, 0, 0, 4'h0, 32'h0, 1, 2));
    do_op("lw_rd0", 1, 0, 3'b010, 32'h10C, 32'h0, 5'd0, 32'h12345678, 1,
          mk(5'd0, 0, 32'h0, 0, 0, 2'b00, 32'h10C, 0, 0, 4'h0, 32'h0, 2, 3));
    do_op("timeout", 1, 0, 3'b010, 32'h300, 32'h0, 5'd4, 32'h0, -1,
          mk(5'd4, 0, 32'h0, 0, 1, 2'b10, 32'h300, 0, 0, 4'h0, 32'h0, 16, 17));

    // Late ack after timeout is ignored
    for (int i = 0; i < 2; i++) begin
      dmem.ack = 1'b1; dmem.rdata = 32'hFFFFFFFF;
      #1;
      check("late_ack.req", 32'(dmem.req), 32'd0);
      check("late_ack.wb_valid", 32'(wb_valid), 32'd0);
      check("late_ack.fault", 32'(fault), 32'd0);
      step();
    end
    dmem.ack = 1'b0;

    // Reset in the second BUSY cycle abandons the access
    ex_valid = 1'b1; ex_mem_re = 1'b1; ex_mem_we = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h100; ex_addr_rd = 5'd7;
    step();
    check("rst_mid.busy1_req", 32'(dmem.req), 32'd1);
    step();
    check("rst_mid.busy2_req", 32'(dmem.req), 32'd1);
    reset = 1'b1; ex_valid = 1'b0; ex_mem_re = 1'b0;
    #1;
    check("rst_mid.stall_forced", 32'(stall), 32'd0);
    step();
    check_all_zero("rst_mid");
    reset = 1'b0; dmem.ack = 1'b1; dmem.rdata = 32'h77777777;
    step();
    check("rst_mid.late_ack_wb", 32'(wb_valid), 32'd0);
    check("rst_mid.late_ack_req", 32'(dmem.req), 32'd0);
    dmem.ack = 1'b0;
    do_op("lw_after_rst", 1, 0, 3'b010, 32'h100, 32'h0, 5'd7, 32'h13579BDF, 0,
          mk(5'd7, 1, 32'h13579BDF, 1, 0, 2'b00, 32'h100, 0, 0, 4'h0, 32'h0, 1, 2));

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning BUSY cycles without dmem_ack before a timeout fault.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clock  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 ex_valid  in  1  EX stage holds a valid instruction.
REQ-005 ex_mem_re / ex_mem_we  in  1 each  load / store request from EX.
REQ-006 ex_funct3  in  3  access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 ex_addr  in  32  effective address (EX ALU result); ex_store_data  in  32  rs2 value; ex_addr_rd  in  5  destination register.
REQ-008 stall  out  1  freezes PC, IF/ID, ID/EX and EX stages while high.
REQ-009 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32 (bits 1:0 zero); dmem_be  out  4; dmem_wdata  out  32; dmem_ack  in  1; dmem_rdata  in  32.
REQ-010 wb_valid  out  1; wb_write  out  1; wb_rd  out  5; wb_data  out  32 (register-file write port).
REQ-011 fault  out  1 (one-cycle pulse); fault_code  out  2 (01 misaligned, 10 timeout, 11 illegal funct3).

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-013 In IDLE with ex_valid and (ex_mem_re or ex_mem_we), the block SHALL capture the address, data, funct3, rd and op, then go to BUSY; if the access is illegal, it SHALL go to DONE with a fault.
REQ-014 ex_mem_re SHALL take priority over ex_mem_we when both are set.
REQ-015 stall SHALL be high in BUSY, and in IDLE while a memory operation is presented; stall SHALL be low in DONE.
REQ-016 DONE SHALL ignore all EX inputs for one cycle (the pipeline advances past the held instruction), then return to IDLE.
REQ-017 In BUSY, dmem_req SHALL be held high with stable address, be, we and wdata until dmem_ack.
REQ-018 On dmem_ack in BUSY, the block SHALL sample dmem_rdata and move to DONE; dmem_ack outside BUSY SHALL be ignored.
REQ-019 Minimum latency SHALL be 3 cycles (accept, BUSY with ack, DONE); each wait cycle SHALL add one.
REQ-020 Byte lanes: SB gives be = 1 shifted by addr[1:0] and byte replicated x4; SH gives be 0011 or 1100 by addr[1] and halfword replicated x2; SW gives be 1111.
REQ-021 Loads: the selected lane SHALL be extracted by addr[1:0]; LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend to 32 bits.
REQ-022 A halfword at odd addr, or a word with addr[1:0] != 0, SHALL fault with code 01 and issue no dmem_req.
REQ-023 Store funct3 other than 000/001/010, or load funct3 other than 000/001/010/100/101, SHALL fault with code 11 and issue no dmem_req.
REQ-024 When the BUSY cycle counter reaches TIMEOUT_CYCLES, the block SHALL drop dmem_req, go to DONE, and set fault code 10.
REQ-025 In DONE: wb_valid = 1; wb_write = 1 only for a fault-free load with rd != 0; wb_rd = the captured rd; fault SHALL pulse if a fault was recorded.

Reset
REQ-026 While reset is high, stall SHALL be forced to 0.
REQ-027 At a clock edge with reset high, the FSM SHALL go to IDLE and the counter to 0.
REQ-028 At a clock edge with reset high, all registered outputs SHALL clear: dmem_req, dmem_we, wb_valid, wb_write and fault to 0, and every bus to 0.
REQ-029 Reset mid-transaction SHALL abandon the access; a late dmem_ack SHALL then be ignored.

Structure
REQ-030 The shared package riscv_pkg SHALL hold the funct3 size constants, the LSU state encoding and the fault codes.
REQ-031 Byte-lane steering and load extension SHALL live in one combinational sub-module, lsu_align.

Verification
REQ-032 LW at 0x100 with ack in the first BUSY cycle and rdata 0xDEADBEEF, rd=5: wb_write=1, wb_data=0xDEADBEEF, stall high for exactly 2 cycles.
REQ-033 LB at 0x103 with rdata 0x80112233 gives 0xFFFFFF80; LBU at the same address gives 0x00000080.
REQ-034 SH at 0x202 with data 0x0000ABCD gives be=1100, wdata=0xABCDABCD, wb_write=0; with 3 wait cycles, dmem_req SHALL stay stable for 4 cycles.
REQ-035 LW at 0x101: no dmem_req, fault pulse with code 01, wb_write=0; LH at 0x101: same result.
REQ-036 With no ack for 16 BUSY cycles: fault code 10, then IDLE; a late ack SHALL be ignored.
REQ-037 Reset asserted in the 2nd BUSY cycle: next cycle all outputs are 0; a subsequent LW SHALL complete normally.
